// File: rtl/dram_pack.sv
// Shared state type and default sizing for the DRAM burst datapath.
package dram_pack;
    typedef enum logic [2:0] {
        IDLE, WR_PRE, WR_BURST, WR_POST, RD_WAIT, RD_BURST, RD_DONE
    } dbd_state_t;

    localparam int DQ_WIDTH_DEF    = 32;
    localparam int BURST_LEN_DEF   = 8;
    localparam int WR_PREAMBLE_DEF = 2;
    localparam int RD_TIMEOUT_DEF  = 16;
endpackage

// File: rtl/dqs_beat_det.sv
// Read-side capture: registers DQ/DQS, flags known-value DQS edges and
// counts cycles since the last counted edge for the read timeout.
module dqs_beat_det #(
    parameter int DQ_WIDTH   = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [DQ_WIDTH-1:0] dq_pin,
    input  logic                dqs_pin,
    input  logic                tmo_en,
    input  logic                rise_only,
    output logic [DQ_WIDTH-1:0] dq_q,
    output logic                rise,
    output logic                fall,
    output logic                timeout
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(RD_TIMEOUT);

    logic          dqs_q, dqs_q2;
    logic          known, edge_cnt;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dq_q   <= '0;
            dqs_q  <= 1'b0;
            dqs_q2 <= 1'b0;
        end else begin
            dq_q   <= dq_pin;
            dqs_q  <= dqs_pin;
            dqs_q2 <= dqs_q;
        end
    end

    // A floating or contended strobe must never be taken as a beat.
    assign known    = !$isunknown({dqs_q, dqs_q2});
    assign rise     = known && dqs_q && !dqs_q2;
    assign fall     = known && !dqs_q && dqs_q2;
    assign edge_cnt = rise || (fall && !rise_only);
    assign timeout  = tmo_en && (tmo_cnt == TMO_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt <= '0;
        end else if (!tmo_en || edge_cnt) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dram_burst_datapath.sv
// DQ/DQS/DM burst datapath: one write or read burst at a time.
// state    | meaning
// IDLE     | pins released, waiting for wr_req / rd_req
// WR_PRE   | DQS driven low for the write preamble
// WR_BURST | one write beat per cycle, DQS toggling
// WR_POST  | DQS low, last beat held, wr_done
// RD_WAIT  | waiting for the first rising DQS edge
// RD_BURST | capturing one beat per DQS edge
// RD_DONE  | publish captured burst, rd_valid next cycle
module dram_burst_datapath
    import dram_pack::*;
#(
    parameter int DQ_WIDTH    = DQ_WIDTH_DEF,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int WR_PREAMBLE = WR_PREAMBLE_DEF,
    parameter int RD_TIMEOUT  = RD_TIMEOUT_DEF
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            wr_req,
    input  logic                            rd_req,
    input  logic                            clear,
    input  logic [$clog2(BURST_LEN)-1:0]    col_sel,
    input  logic [BURST_LEN*DQ_WIDTH-1:0]   wr_data,
    input  logic [BURST_LEN*DQ_WIDTH/8-1:0] wr_mask,
    output logic                            busy,
    output logic                            wr_done,
    output logic                            rd_valid,
    output logic                            rd_err,
    output logic [BURST_LEN*DQ_WIDTH-1:0]   rd_burst,
    output logic [DQ_WIDTH-1:0]             rd_word,
    inout  wire  [DQ_WIDTH-1:0]             DQ,
    inout  wire                             DQS_t,
    inout  wire                             DQS_c,
    inout  wire  [DQ_WIDTH/8-1:0]           DM_n
);
    localparam int NB = DQ_WIDTH / 8;
    localparam int CW = $clog2(BURST_LEN);
    localparam int BW = CW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'(WR_PREAMBLE - 1);

    dbd_state_t                  state, state_nx;
    logic [BW-1:0]               beat;
    logic [BURST_LEN*DQ_WIDTH-1:0] wr_sh, rd_buf;
    logic [BURST_LEN*NB-1:0]     wr_msk;
    logic [CW-1:0]               col_q;
    logic [DQ_WIDTH-1:0]         dq_q, dq_o;
    logic [NB-1:0]               dm_o;
    logic                        dqs_o, wr_drv;
    logic                        rise, fall, timeout, rd_active;

    assign rd_active = (state == RD_WAIT) || (state == RD_BURST);

    dqs_beat_det #(
        .DQ_WIDTH   (DQ_WIDTH),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_det (
        .CLK       (CLK),
        .nRST      (nRST),
        .dq_pin    (DQ),
        .dqs_pin   (DQS_t),
        .tmo_en    (rd_active),
        .rise_only (state == RD_WAIT),
        .dq_q      (dq_q),
        .rise      (rise),
        .fall      (fall),
        .timeout   (timeout)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (wr_req) state_nx = WR_PRE;
                          else if (rd_req) state_nx = RD_WAIT;
                WR_PRE:   if (beat == PRE_LAST) state_nx = WR_BURST;
                WR_BURST: if (beat == LAST_BEAT) state_nx = WR_POST;
                WR_POST:  state_nx = IDLE;
                RD_WAIT:  if (timeout) state_nx = IDLE;
                          else if (rise) state_nx = RD_BURST;
                RD_BURST: if (timeout) state_nx = IDLE;
                          else if ((rise || fall) && beat == LAST_BEAT) state_nx = RD_DONE;
                RD_DONE:  state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            beat     <= '0;
            wr_sh    <= '0;
            wr_msk   <= '0;
            col_q    <= '0;
            rd_buf   <= '0;
            rd_burst <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (wr_req) begin
                        wr_sh  <= wr_data;
                        wr_msk <= wr_mask;
                    end else if (rd_req) begin
                        col_q <= col_sel;
                    end
                end
                WR_PRE: beat <= (beat == PRE_LAST) ? '0 : beat + 1'b1;
                // The last beat is not shifted out so WR_POST can keep holding it.
                WR_BURST: if (beat != LAST_BEAT) begin
                    beat   <= beat + 1'b1;
                    wr_sh  <= wr_sh >> DQ_WIDTH;
                    wr_msk <= wr_msk >> NB;
                end
                RD_WAIT: if (rise) begin
                    rd_buf[DQ_WIDTH-1:0] <= dq_q;
                    beat                 <= BW'(1);
                end
                RD_BURST: if (rise || fall) begin
                    rd_buf[beat[CW-1:0]*DQ_WIDTH +: DQ_WIDTH] <= dq_q;
                    beat <= beat + 1'b1;
                end
                RD_DONE: if (!clear) begin
                    rd_burst <= rd_buf;
                    rd_word  <= rd_buf[col_q*DQ_WIDTH +: DQ_WIDTH];
                    rd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign wr_done = (state == WR_POST) && !clear;
    assign rd_err  = timeout && !clear;

    assign wr_drv = (state == WR_PRE) || (state == WR_BURST) || (state == WR_POST);

    always_comb begin
        dq_o  = '0;
        dm_o  = '1;
        dqs_o = 1'b0;
        if (state == WR_BURST || state == WR_POST) begin
            dq_o = wr_sh[DQ_WIDTH-1:0];
            dm_o = wr_msk[NB-1:0];
        end
        if (state == WR_BURST) dqs_o = ~beat[0];
    end

    assign DQ    = wr_drv ? dq_o   : 'z;
    assign DQS_t = wr_drv ? dqs_o  : 1'bz;
    assign DQS_c = wr_drv ? ~dqs_o : 1'bz;
    assign DM_n  = wr_drv ? dm_o   : 'z;
endmodule

// File: doc/dram_burst_datapath.md
Name: dram_burst_datapath

Overview:
Parametrised DQ/DQS/DM burst datapath between the DRAM controller's command FSM and the DRAM pins. It runs one write or one read burst at a time.
- Write: drives a latched burst onto DQ with a generated DQS strobe and per-byte DM_n.
- Read: captures a DQS-strobed burst into a buffer and returns the full burst plus one selected column word.
- Adds byte masking, configurable burst length and preamble, read timeout, abort, and completion handshakes.

Parameters:
DQ_WIDTH, 32, data bits per beat (multiple of 8)
BURST_LEN, 8, beats per burst (power of 2, 2..16)
WR_PREAMBLE, 2, cycles DQS is driven low before the first write beat (1..4)
RD_TIMEOUT, 16, maximum cycles allowed without a DQS edge during a read before abort

Ports:
CLK  in  1  beat clock, one DQ beat per cycle
nRST  in  1  asynchronous active-low reset
wr_req  in  1  start write burst; sampled only in IDLE
rd_req  in  1  start read burst; sampled only in IDLE
clear  in  1  synchronous abort to IDLE
col_sel  in  $clog2(BURST_LEN)  beat index returned on rd_word; latched with rd_req
wr_data  in  BURST_LEN*DQ_WIDTH  write burst, beat i at bits [i*DQ_WIDTH +: DQ_WIDTH]
wr_mask  in  BURST_LEN*DQ_WIDTH/8  1 = write this byte
busy  out  1  high in every state except IDLE
wr_done  out  1  one-cycle pulse at write completion
rd_valid  out  1  one-cycle pulse when rd_burst and rd_word are valid
rd_err  out  1  one-cycle pulse on read timeout
rd_burst  out  BURST_LEN*DQ_WIDTH  captured read burst
rd_word  out  DQ_WIDTH  captured beat selected by col_sel
DQ  inout  DQ_WIDTH  data bus
DQS_t, DQS_c  inout  1 each  strobe pair; DQS_c = ~DQS_t whenever driven
DM_n  inout  DQ_WIDTH/8  active-low data mask (0 = byte masked)

Behaviour:
Reset values:
- State IDLE; busy, wr_done, rd_valid, rd_err = 0.
- rd_burst, rd_word = 0; beat counter = 0.
- DQ, DQS_t, DQS_c and DM_n all released ('z).

States: IDLE, WR_PRE, WR_BURST, WR_POST, RD_WAIT, RD_BURST, RD_DONE.

IDLE:
- wr_req → WR_PRE; wr_data and wr_mask are latched that cycle.
- rd_req → RD_WAIT; col_sel is latched that cycle.
- wr_req and rd_req together: the write wins and rd_req is ignored.

Write path:
- WR_PRE lasts exactly WR_PREAMBLE cycles. DQS_t is driven 0, DM_n is driven all-ones, DQ is driven 0.
- WR_BURST lasts BURST_LEN cycles with beat b = 0..BURST_LEN-1.
  - DQ = latched beat b.
  - DM_n[k] = latched mask bit b*(DQ_WIDTH/8)+k.
  - DQS_t = 1 on even b, 0 on odd b.
- WR_POST lasts 1 cycle: DQS_t driven 0, DQ holds the last beat. wr_done pulses in this cycle.
- Next cycle → IDLE and all pins are released.
- Total write latency from the wr_req cycle to the wr_done cycle is WR_PREAMBLE+BURST_LEN+1.

Read path:
- DQ and DQS_t are registered every cycle into dq_q and dqs_q; dqs_q2 holds the previous dqs_q.
- An edge is dqs_q != dqs_q2 with both values known (not X/Z).
- RD_WAIT: only a rising edge counts. It stores dq_q into buffer[0], sets beat = 1, and moves to RD_BURST.
- RD_BURST: each edge of either polarity stores dq_q into buffer[beat] and increments beat.
- After beat BURST_LEN-1 is stored → RD_DONE.
- RD_DONE lasts 1 cycle:
  - rd_burst ← buffer and rd_word ← buffer[latched col_sel], both registered.
  - rd_valid pulses on the cycle these outputs become valid.
  - Then → IDLE.
- rd_burst and rd_word hold their values until the next successful read.
- Timeout counter:
  - Resets on every counted edge.
  - Reaching RD_TIMEOUT in RD_WAIT or RD_BURST causes: rd_err pulses, state → IDLE, outputs are not updated, rd_valid stays 0.
- The block never drives DQ, DQS or DM_n in read states.

Abort and reset:
- clear in any state → IDLE next cycle. Pins are released; no done, valid or err pulse. A wr_req/rd_req in the same cycle is ignored.
- nRST asserted mid-burst: pins are released immediately (asynchronous) and all registers take their reset values.
- wr_req/rd_req while busy is ignored; no queuing.

Widths:
- Beat counter is $clog2(BURST_LEN)+1 bits.
- Timeout counter is $clog2(RD_TIMEOUT+1) bits and saturates.

Decomposition:
- dram_pack holds:
  - the state enum typedef dbd_state_t;
  - default constants DQ_WIDTH_DEF, BURST_LEN_DEF, WR_PREAMBLE_DEF, RD_TIMEOUT_DEF.
- Sub-module dqs_beat_det owns the read-side logic: the DQS/DQ input registers, known-value edge detection (rise/fall outputs), and the timeout counter.
- The top level owns the FSM, the write shifter, the read buffer and the tristate drivers.

Test Plan:
1. Defaults, wr_req with beats 0x11111111..0x88888888 and mask all ones → 2 cycles DQS_t=0, then 8 beats on DQ with DQS_t alternating 1,0,…, DM_n=4'hF; wr_done exactly 11 cycles after wr_req; pins 'z the next cycle.
2. Write with beat 3 mask = 4'b0101 → during beat 3, DM_n=4'b0101 and DQ = beat 3 data; all other beats DM_n=4'hF.
3. rd_req with col_sel=5; bench drives a DQS preamble low then 8 toggles with DQ=0xA0..0xA7 → rd_burst holds 0xA0..0xA7, rd_word=0xA5, rd_valid pulses once, busy drops the next cycle.
4. rd_req with no DQS activity → rd_err pulses 16 cycles after entering RD_WAIT; rd_valid stays 0; rd_burst keeps its previous value.
5. wr_req and rd_req asserted together → write sequence only; busy drops after wr_done; no read activity. clear asserted mid-WR_BURST (beat 4) → pins 'z next cycle, no wr_done.
6. nRST pulsed low during RD_BURST beat 3 → all outputs take reset values immediately; a following rd_req completes a normal burst.
